// File: rtl/axi_lite_timer_regs.sv
// axi_lite_timer_regs: AXI-Lite slave with CTRL / SCRATCH / COUNT / ID registers.
// Independent AW/W capture, registered B and R responses, SLVERR on decode miss.
// Optional compare interrupt (CMP, IRQ_STAT, CTRL.IE) enabled by `define AXIL_TIMER_IRQ_EN.
module axi_lite_timer_regs #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h4000_0000,
    parameter logic [DATA_W-1:0]  ID_VALUE  = 32'h5449_4D31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              irq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [5:0] OFF_CTRL     = 6'd0;
    localparam logic [5:0] OFF_SCRATCH  = 6'd1;
    localparam logic [5:0] OFF_COUNT    = 6'd2;
    localparam logic [5:0] OFF_ID       = 6'd3;
    localparam logic [5:0] OFF_CMP      = 6'd4;
    localparam logic [5:0] OFF_IRQ_STAT = 6'd5;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_RESP } r_state_e;

    function automatic logic addr_hit(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8];
    endfunction

    function automatic logic off_mapped(input logic [5:0] off);
        case (off)
            OFF_CTRL, OFF_SCRATCH, OFF_COUNT, OFF_ID: return 1'b1;
`ifdef AXIL_TIMER_IRQ_EN
            OFF_CMP, OFF_IRQ_STAT:                    return 1'b1;
`endif
            default:                                  return 1'b0;
        endcase
    endfunction

    // ---------------- write channel ----------------
    w_state_e          w_state_q, w_state_d;
    logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              aw_hs, w_hs, wr_commit, wr_err, wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [5:0]        wr_off;

    // Combine already-captured and same-cycle handshakes so the commit lands on
    // the edge that completes the pair.
    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign wr_addr   = aw_got_q ? awaddr_q : awaddr;
    assign wr_data   = w_got_q ? wdata_q : wdata;
    assign wr_off    = wr_addr[7:2];
    assign wr_commit = (w_state_q == W_IDLE) & (aw_got_q | aw_hs) & (w_got_q | w_hs);
    assign wr_err    = !addr_hit(wr_addr) || !off_mapped(wr_off);
    assign wr_en     = wr_commit & ~wr_err;

    // Write FSM state and capture registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            bresp_q   <= bresp_d;
        end
    end

    // Write FSM next state: capture AW/W independently, commit once both are present.
    always_comb begin
        // NOTE: defaults first so no path leaves a combinational variable unassigned (no latch).
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (wr_commit) begin
                    w_state_d = W_RESP;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    if (aw_hs) begin
                        aw_got_d = 1'b1;
                        awaddr_d = awaddr;
                    end
                    if (w_hs) begin
                        w_got_d = 1'b1;
                        wdata_d = wdata;
                    end
                end
            end
            W_RESP: if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs; readies are masked during reset.
    always_comb begin
        awready = (w_state_q == W_IDLE) & ~aw_got_q & ~reset;
        wready  = (w_state_q == W_IDLE) & ~w_got_q & ~reset;
        bvalid  = (w_state_q == W_RESP);
        bresp   = bresp_q;
    end

    // ---------------- register file ----------------
    logic              ctrl_en_q, ctrl_en_d;
    logic              ctrl_ie;
    logic [DATA_W-1:0] scratch_q, scratch_d;
    logic [DATA_W-1:0] count_q, count_d;
`ifdef AXIL_TIMER_IRQ_EN
    logic              ctrl_ie_q, ctrl_ie_d;
    logic [DATA_W-1:0] cmp_q, cmp_d;
    logic              irq_stat_q, irq_stat_d;
    logic              irq_q, irq_d;
    assign ctrl_ie = ctrl_ie_q;
`else
    assign ctrl_ie = 1'b0;
`endif

    // Register next state: counter runs on the pre-commit EN; CLR overrides the increment.
    always_comb begin
        ctrl_en_d = ctrl_en_q;
        scratch_d = scratch_q;
        count_d   = count_q + DATA_W'(ctrl_en_q);
`ifdef AXIL_TIMER_IRQ_EN
        ctrl_ie_d  = ctrl_ie_q;
        cmp_d      = cmp_q;
        irq_stat_d = irq_stat_q;
        if (wr_en && wr_off == OFF_CMP)                  cmp_d      = wr_data;
        if (wr_en && wr_off == OFF_IRQ_STAT && wr_data[0]) irq_stat_d = 1'b0;
        if (wr_en && wr_off == OFF_CTRL)                 ctrl_ie_d  = wr_data[2];
        // A compare match wins over a same-cycle clear.
        if (ctrl_en_q && count_q == cmp_q)               irq_stat_d = 1'b1;
        irq_d = irq_stat_d & ctrl_ie_d;
`endif
        if (wr_en && wr_off == OFF_CTRL) begin
            ctrl_en_d = wr_data[0];
            if (wr_data[1]) count_d = '0;
        end
        if (wr_en && wr_off == OFF_SCRATCH) scratch_d = wr_data;
    end

    // Register file state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en_q <= 1'b0;
            scratch_q <= '0;
            count_q   <= '0;
`ifdef AXIL_TIMER_IRQ_EN
            ctrl_ie_q  <= 1'b0;
            cmp_q      <= '0;
            irq_stat_q <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            ctrl_en_q <= ctrl_en_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
`ifdef AXIL_TIMER_IRQ_EN
            ctrl_ie_q  <= ctrl_ie_d;
            cmp_q      <= cmp_d;
            irq_stat_q <= irq_stat_d;
            irq_q      <= irq_d;
`endif
        end
    end

`ifdef AXIL_TIMER_IRQ_EN
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // ---------------- read channel ----------------
    r_state_e          r_state_q, r_state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, rd_mux_data;
    logic [1:0]        rresp_q, rresp_d;
    logic              rd_mux_err, ar_hs;

    assign ar_hs = arvalid & arready;

    // Read decode mux on the live address; misses return zero data.
    always_comb begin
        rd_mux_data = '0;
        rd_mux_err  = 1'b0;
        if (!addr_hit(araddr)) begin
            rd_mux_err = 1'b1;
        end else begin
            case (araddr[7:2])
                OFF_CTRL:     rd_mux_data = {{(DATA_W-3){1'b0}}, ctrl_ie, 1'b0, ctrl_en_q};
                OFF_SCRATCH:  rd_mux_data = scratch_q;
                OFF_COUNT:    rd_mux_data = count_q;
                OFF_ID:       rd_mux_data = ID_VALUE;
`ifdef AXIL_TIMER_IRQ_EN
                OFF_CMP:      rd_mux_data = cmp_q;
                OFF_IRQ_STAT: rd_mux_data = {{(DATA_W-1){1'b0}}, irq_stat_q};
`endif
                default:      rd_mux_err  = 1'b1;
            endcase
        end
    end

    // Read FSM state and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Read FSM next state: sample data on acceptance, hold until rready.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: if (ar_hs) begin
                r_state_d = R_RESP;
                rdata_d   = rd_mux_data;
                rresp_d   = rd_mux_err ? RESP_SLVERR : RESP_OKAY;
            end
            R_RESP: if (rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        arready = (r_state_q == R_IDLE) & ~reset;
        rvalid  = (r_state_q == R_RESP);
        rdata   = rdata_q;
        rresp   = rresp_q;
    end

    // Byte-lane bits of the address carry no meaning here.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{wr_addr[1:0], araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_timer_regs.sv
// Directed self-checking bench for axi_lite_timer_regs.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_axi_lite_timer_regs;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] ID   = 32'h5449_4D31;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_lite_timer_regs dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Same-cycle AW+W write with bready held high; returns bresp.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
        logic aw_fire, w_fire;
        int   cyc;
        @(negedge clk);
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        cyc = 0;
        while ((awvalid || wvalid) && cyc < 20) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk);
            cyc++;
            if (aw_fire) awvalid = 1'b0;
            if (w_fire)  wvalid  = 1'b0;
        end
        while (!bvalid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("wr_bvalid_seen", {31'b0, bvalid}, 32'd1);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    // Read with rready held high; returns rdata and rresp.
    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic ar_fire;
        int   cyc;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        cyc = 0;
        while (arvalid && cyc < 20) begin
            ar_fire = arvalid && arready;
            @(negedge clk);
            cyc++;
            if (ar_fire) arvalid = 1'b0;
        end
        while (!rvalid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("rd_rvalid_seen", {31'b0, rvalid}, 32'd1);
        data = rdata;
        resp = rresp;
        @(negedge clk);
        rready = 1'b0; arvalid = 1'b0;
    endtask

    // Read with rready low for four cycles; response must stay put.
    task automatic read_hold(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_data, input logic [1:0] exp_resp);
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        check({tag, "_arready"}, {31'b0, arready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            arvalid = 1'b0;
            check({tag, "_rvalid_hold"}, {31'b0, rvalid}, 32'd1);
            check({tag, "_arready_low"}, {31'b0, arready}, 32'd0);
            check({tag, "_rdata_hold"}, rdata, exp_data);
            check({tag, "_rresp_hold"}, {30'b0, rresp}, {30'b0, exp_resp});
        end
        rready = 1'b1;
        @(negedge clk);
        check({tag, "_rvalid_clear"}, {31'b0, rvalid}, 32'd0);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          cyc;

        // Reset: readies forced low, responses idle.
        repeat (2) @(negedge clk);
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_wready",  {31'b0, wready},  32'd0);
        check("rst_arready", {31'b0, arready}, 32'd0);
        check("rst_bvalid",  {31'b0, bvalid},  32'd0);
        check("rst_rvalid",  {31'b0, rvalid},  32'd0);
        check("rst_rdata",   rdata, 32'd0);
        check("rst_irq",     {31'b0, irq}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_awready", {31'b0, awready}, 32'd1);
        check("idle_arready", {31'b0, arready}, 32'd1);

        // ID and CTRL reset values.
        axi_read(BASE + 32'h0C, d, r);
        check("id_data", d, ID);
        check("id_resp", {30'b0, r}, 32'd0);
        axi_read(BASE + 32'h0D, d, r);
        check("id_lsb_ignored", d, ID);
        axi_read(BASE + 32'h00, d, r);
        check("ctrl_reset", d, 32'd0);

        // Same-cycle AW+W with bready low for three cycles.
        @(negedge clk);
        awaddr = BASE + 32'h04; wdata = 32'hDEAD_BEEF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        check("aw_w_awready", {31'b0, awready}, 32'd1);
        check("aw_w_wready",  {31'b0, wready},  32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            awvalid = 1'b0; wvalid = 1'b0;
            check("bhold_bvalid",  {31'b0, bvalid},  32'd1);
            check("bhold_bresp",   {30'b0, bresp},   32'd0);
            check("bhold_awready", {31'b0, awready}, 32'd0);
            check("bhold_wready",  {31'b0, wready},  32'd0);
        end
        bready = 1'b1;
        @(negedge clk);
        check("bhold_release", {31'b0, bvalid}, 32'd0);
        bready = 1'b0;
        axi_read(BASE + 32'h04, d, r);
        check("scratch_deadbeef", d, 32'hDEAD_BEEF);

        // W two cycles ahead of AW.
        @(negedge clk);
        awaddr = BASE + 32'h04; wdata = 32'h1234_5678; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("wfirst_wready_low", {31'b0, wready},  32'd0);
        check("wfirst_awready",    {31'b0, awready}, 32'd1);
        check("wfirst_no_b",       {31'b0, bvalid},  32'd0);
        @(negedge clk);
        check("wfirst_no_b2",      {31'b0, bvalid},  32'd0);
        awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("wfirst_bvalid", {31'b0, bvalid}, 32'd1);
        check("wfirst_bresp",  {30'b0, bresp},  32'd0);
        @(negedge clk);
        check("wfirst_single_b", {31'b0, bvalid}, 32'd0);
        bready = 1'b0;
        axi_read(BASE + 32'h04, d, r);
        check("scratch_12345678", d, 32'h1234_5678);

        // Counter enable, then clear+stop.
        axi_write(BASE + 32'h00, 32'h1, r);
        check("ctrl_en_resp", {30'b0, r}, 32'd0);
        repeat (10) @(negedge clk);
        axi_read(BASE + 32'h08, d, r);
        check("count_running_range", {31'b0, (d >= 32'd9 && d <= 32'd12)}, 32'd1);
        axi_write(BASE + 32'h00, 32'h2, r);
        axi_read(BASE + 32'h08, d, r);
        check("count_cleared", d, 32'd0);
        axi_read(BASE + 32'h00, d, r);
        check("ctrl_after_clr", d, 32'd0);
        repeat (3) @(negedge clk);
        axi_read(BASE + 32'h08, d, r);
        check("count_stopped", d, 32'd0);

        // Reserved CTRL bits read zero; IE bit only with the interrupt option.
        axi_write(BASE + 32'h00, 32'hFFFF_FFFD, r);
        axi_read(BASE + 32'h00, d, r);
`ifdef AXIL_TIMER_IRQ_EN
        check("ctrl_reserved", d, 32'd5);
`else
        check("ctrl_reserved", d, 32'd1);
`endif
        axi_write(BASE + 32'h00, 32'h2, r);

        // Writes to RO registers are ignored with OKAY.
        axi_write(BASE + 32'h08, 32'h0000_FFFF, r);
        check("ro_count_resp", {30'b0, r}, 32'd0);
        axi_write(BASE + 32'h0C, 32'h0, r);
        check("ro_id_resp", {30'b0, r}, 32'd0);
        axi_read(BASE + 32'h08, d, r);
        check("ro_count_kept", d, 32'd0);
        axi_read(BASE + 32'h0C, d, r);
        check("ro_id_kept", d, ID);

        // Decode errors.
        axi_write(BASE + 32'h104, 32'h0000_0BAD, r);
        check("miss_wr_resp", {30'b0, r}, 32'd2);
        axi_read(BASE + 32'h04, d, r);
        check("miss_no_alias", d, 32'h1234_5678);
        axi_read(BASE + 32'h100, d, r);
        check("miss_rd_resp", {30'b0, r}, 32'd2);
        check("miss_rd_data", d, 32'd0);
        axi_write(BASE + 32'h20, 32'h1, r);
        check("unmapped_wr_resp", {30'b0, r}, 32'd2);
        read_hold("hold_scratch", BASE + 32'h04, 32'h1234_5678, 2'b00);
        read_hold("hold_slverr",  BASE + 32'h20, 32'h0, 2'b10);

`ifdef AXIL_TIMER_IRQ_EN
        axi_write(BASE + 32'h14, 32'h1, r);
        axi_write(BASE + 32'h10, 32'd20, r);
        check("cmp_wr_resp", {30'b0, r}, 32'd0);
        axi_read(BASE + 32'h10, d, r);
        check("cmp_readback", d, 32'd20);
        axi_write(BASE + 32'h00, 32'h5, r);
        check("irq_low_early", {31'b0, irq}, 32'd0);
        cyc = 0;
        while (!irq && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("irq_rise", {31'b0, irq}, 32'd1);
        axi_read(BASE + 32'h14, d, r);
        check("irq_stat", d, 32'd1);
        axi_write(BASE + 32'h14, 32'h1, r);
        check("irq_w1c_resp", {30'b0, r}, 32'd0);
        check("irq_cleared", {31'b0, irq}, 32'd0);
`else
        check("irq_tied_low", {31'b0, irq}, 32'd0);
        axi_write(BASE + 32'h10, 32'd20, r);
        check("cmp_absent_wr", {30'b0, r}, 32'd2);
        axi_read(BASE + 32'h14, d, r);
        check("stat_absent_rd", {30'b0, r}, 32'd2);
        check("stat_absent_data", d, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
